// File: rtl/sine_phase_to_amp_pkg.sv
// Shared widths and quarter-wave table generator for the sine
// phase-to-amplitude stage.
package sine_phase_to_amp_pkg;

    localparam int PHASE_W = 16;
    localparam int ADDR_W  = 10;
    localparam int AMP_W   = 16;
    localparam int QW      = PHASE_W - 2;
    localparam int F       = QW - ADDR_W;
    localparam int N       = 1 << ADDR_W;
    localparam int FS      = (1 << (AMP_W - 1)) - 1;

    // pi/2 in Q30
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // round(FS*sin(pi/2*n/N)) by fixed-point Taylor series, so the
    // table elaborates as constants without an external file.
    function automatic logic [AMP_W-2:0] quarter_sine(input int n);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint s;
        x    = (HALF_PI_Q30 * longint'(n)) >>> ADDR_W;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 9; k++) begin
            term = (term * x2) >>> 30;
            term = -term / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        s = (acc * longint'(FS) + (64'sd1 <<< 29)) >>> 30;
        if (s > longint'(FS)) s = longint'(FS);
        if (s < 64'sd0) s = 64'sd0;
        return s[AMP_W-2:0];
    endfunction

endpackage

// File: rtl/sine_phase_to_amp_if.sv
// Phase-in / sample-out bundle between the phase accumulator,
// the sine stage and the voice mixer.
interface sine_phase_to_amp_if;
    import sine_phase_to_amp_pkg::*;

    logic [PHASE_W-1:0]      i_phase;
    logic                    i_valid;
    logic signed [AMP_W-1:0] o_sample;
    logic                    o_valid;

    modport master (
        output i_phase, i_valid,
        input  o_sample, o_valid
    );

    modport slave (
        input  i_phase, i_valid,
        output o_sample, o_valid
    );

endinterface

// File: rtl/quarter_sine_rom.sv
// Two-port synchronous quarter-wave sine ROM, N+1 entries,
// unsigned magnitudes 0..FS.
module quarter_sine_rom
    import sine_phase_to_amp_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W:0]   i_addr_a,
    input  logic [ADDR_W:0]   i_addr_b,
    output logic [AMP_W-2:0]  o_q_a,
    output logic [AMP_W-2:0]  o_q_b
);

    logic [AMP_W-2:0] rom [0:N];

    for (genvar g = 0; g <= N; g++) begin : g_rom
        localparam logic [AMP_W-2:0] VAL = quarter_sine(g);
        assign rom[g] = VAL;
    end

    // registered read of both interpolation endpoints
    always_ff @(posedge clk) begin
        if (en) begin
            o_q_a <= rom[i_addr_a];
            o_q_b <= rom[i_addr_b];
        end
    end

endmodule

// File: rtl/sine_phase_to_amp.sv
// Phase word to signed sine sample: quadrant fold, table lookup,
// linear interpolation, sign restore. Four enabled stages.
module sine_phase_to_amp
    import sine_phase_to_amp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    sine_phase_to_amp_if.slave bus
);

    localparam logic [QW:0]     R_MAX = {1'b1, {QW{1'b0}}};
    localparam logic [ADDR_W:0] A_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        q;
    logic [QW-1:0]     low;
    logic [QW:0]       r;
    logic [ADDR_W:0]   a_c;
    logic [ADDR_W:0]   a1_c;

    logic [ADDR_W:0]   s1_a;
    logic [ADDR_W:0]   s1_a1;
    logic [F-1:0]      s1_f;
    logic              s1_neg;

    logic [AMP_W-2:0]  q_a;
    logic [AMP_W-2:0]  q_b;
    logic [F-1:0]      s2_f;
    logic              s2_neg;

    logic [AMP_W-2:0]  diff;
    logic [AMP_W-2+F:0] s3_d;
    logic [AMP_W-2:0]  s3_base;
    logic              s3_neg;

    logic [AMP_W-2:0]  d_hi;
    logic [AMP_W-1:0]  m;

    logic [3:0]              vld;
    logic signed [AMP_W-1:0] out_sample;

    // fold the phase into the first quadrant and split index/fraction
    always_comb begin
        q    = bus.i_phase[PHASE_W-1 -: 2];
        low  = bus.i_phase[QW-1:0];
        r    = q[0] ? (R_MAX - {1'b0, low}) : {1'b0, low};
        a_c  = r[QW:F];
        a1_c = (a_c == A_MAX) ? A_MAX : a_c + (ADDR_W+1)'(1);
    end

    // S1: decoded address pair, fraction and sign
    always_ff @(posedge clk) begin
        if (clk_en) begin
            s1_a   <= a_c;
            s1_a1  <= a1_c;
            s1_f   <= r[F-1:0];
            s1_neg <= q[1];
        end
    end

    quarter_sine_rom u_rom (
        .clk      (clk),
        .en       (clk_en),
        .i_addr_a (s1_a),
        .i_addr_b (s1_a1),
        .o_q_a    (q_a),
        .o_q_b    (q_b)
    );

    // S2 side-band: fraction and sign travel alongside the ROM read
    always_ff @(posedge clk) begin
        if (clk_en) begin
            s2_f   <= s1_f;
            s2_neg <= s1_neg;
        end
    end

    assign diff = q_b - q_a;

    // S3: slope times fraction; table is monotone so diff is unsigned
    always_ff @(posedge clk) begin
        if (clk_en) begin
            s3_d    <= {{F{1'b0}}, diff} * {{(AMP_W-1){1'b0}}, s2_f};
            s3_base <= q_a;
            s3_neg  <= s2_neg;
        end
    end

    assign d_hi = (AMP_W-1)'(s3_d >> F);
    assign m    = {1'b0, s3_base} + {1'b0, d_hi};

    // S4: restore sign; bubbles leave the last sample in place
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sample <= '0;
        end else if (clk_en && vld[2]) begin
            out_sample <= s3_neg ? -m : m;
        end
    end

    // valid chain, flushed by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
        end else if (clk_en) begin
            vld <= {vld[2:0], bus.i_valid};
        end
    end

    assign bus.o_sample = out_sample;
    assign bus.o_valid  = vld[3];

endmodule

// File: tb/tb_sine_phase_to_amp.sv
// Self-checking bench for sine_phase_to_amp: vector table, gated
// enable burst, wrapped sweep and mid-stream reset via a scoreboard.
module tb_sine_phase_to_amp;

    logic clk;
    logic reset;
    logic clk_en;

    sine_phase_to_amp_if bus ();

    sine_phase_to_amp dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] phase;
        int          exp;
    } vec_t;

    typedef struct {
        logic [15:0] phase;
        int          exp;
        bit          approx;
        int          due;
    } sb_t;

    vec_t        vecs [12];
    sb_t         sb [$];
    int          sweep_out [int];
    logic [15:0] sweep_list [$];

    int checks   = 0;
    int failures = 0;
    int e        = 0;
    int pv       = 0;
    int ps       = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic real ideal(input logic [15:0] p);
        return 32767.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 65536.0);
    endfunction

    task automatic check_out(input bit rst, input bit en);
        int  os;
        int  ov;
        bit  exp_v;
        sb_t it;
        real id;
        real err;
        os = int'(bus.o_sample);
        ov = int'(bus.o_valid);
        if (rst) begin
            chk("rst_valid", ov, 0);
            chk("rst_sample", os, 0);
        end else if (!en) begin
            chk("hold_valid", ov, pv);
            chk("hold_sample", os, ps);
        end else begin
            exp_v = (sb.size() > 0) && (sb[0].due == e);
            chk("valid", ov, int'(exp_v));
            if (exp_v) begin
                it = sb.pop_front();
                if (ov == 1) begin
                    if (it.approx) begin
                        id  = ideal(it.phase);
                        err = real'(os) - id;
                        if (err < 0.0) err = -err;
                        checks++;
                        if (err > 2.0) begin
                            failures++;
                            $display("FAIL sweep_err phase=%h actual=%0d required=%f+-2",
                                     it.phase, os, id);
                        end
                        sweep_out[int'(it.phase)] = os;
                    end else begin
                        chk($sformatf("sample_%h", it.phase), os, it.exp);
                    end
                end
            end else if (ov == 0) begin
                chk("bubble_hold", os, ps);
            end
        end
        pv = ov;
        ps = os;
    endtask

    task automatic tick(input bit rst, input bit en, input bit v,
                        input logic [15:0] ph, input bit approx,
                        input int exp);
        sb_t it;
        reset       = rst;
        clk_en      = en;
        bus.i_valid = v;
        bus.i_phase = ph;
        @(posedge clk);
        if (rst) begin
            sb.delete();
        end else if (en) begin
            e++;
            if (v) begin
                it.phase  = ph;
                it.exp    = exp;
                it.approx = approx;
                it.due    = e + 3;
                sb.push_back(it);
            end
        end
        #1;
        check_out(rst, en);
    endtask

    task automatic flush();
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 16'h0, 0, 0);
        chk("flush_empty", sb.size(), 0);
    endtask

    initial begin
        logic [15:0] p;

        vecs[0]  = '{16'h0000,      0};
        vecs[1]  = '{16'h2000,  23170};
        vecs[2]  = '{16'h4000,  32767};
        vecs[3]  = '{16'h6000,  23170};
        vecs[4]  = '{16'h8000,      0};
        vecs[5]  = '{16'hA000, -23170};
        vecs[6]  = '{16'hC000, -32767};
        vecs[7]  = '{16'hE000, -23170};
        vecs[8]  = '{16'h0008,     25};
        vecs[9]  = '{16'h7FF8,     25};
        vecs[10] = '{16'hFFFF,     -3};
        vecs[11] = '{16'h0000,      0};

        bus.i_phase = '0;
        bus.i_valid = 1'b0;
        reset       = 1'b1;
        clk_en      = 1'b1;

        // reset held three clocks with valid input present
        for (int i = 0; i < 3; i++) tick(1, 1, 1, 16'h2000, 0, 0);

        // key phases, interpolation and wrap, back to back from release
        foreach (vecs[i]) tick(0, 1, 1, vecs[i].phase, 0, vecs[i].exp);
        flush();

        // 1-in-4 enable burst with one bubble; junk while disabled
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++)
                tick(0, 0, 1'($urandom), 16'($urandom), 0, 0);
            tick(0, 1, (i != 4), vecs[i].phase, 0, vecs[i].exp);
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++)
                tick(0, 0, 1'($urandom), 16'($urandom), 0, 0);
            tick(0, 1, 0, 16'h0, 0, 0);
        end
        chk("burst_empty", sb.size(), 0);

        // sweep through many wraps, each phase paired with its antipode
        p = 16'hF000;
        for (int i = 0; i < 400; i++) begin
            sweep_list.push_back(p);
            tick(0, 1, 1, p, 1, 0);
            tick(0, 1, 1, p ^ 16'h8000, 1, 0);
            p = p + 16'h1D5F;
        end
        flush();
        foreach (sweep_list[i]) begin
            int k0;
            int k1;
            k0 = int'(sweep_list[i]);
            k1 = int'(sweep_list[i] ^ 16'h8000);
            if (sweep_out.exists(k0) && sweep_out.exists(k1)) begin
                chk($sformatf("sym_%h", sweep_list[i]), sweep_out[k0], -sweep_out[k1]);
            end else begin
                checks++;
                failures++;
                $display("FAIL sym_missing phase=%h actual=absent required=present",
                         sweep_list[i]);
            end
        end

        // reset with two samples in flight drops both
        tick(0, 1, 1, 16'h4000, 0, 32767);
        tick(0, 1, 1, 16'h2000, 0, 23170);
        tick(1, 1, 1, 16'h4000, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 16'h0, 0, 0);
        chk("post_reset_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
